// File: rtl/ram_post_pkg.sv
// Shared types and helpers for the write-posting buffer between a memory master and the HyperRAM arbitrator.
package ram_post_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDACK} state_t;

  localparam int ABITS_DEF = 24;
  localparam int DBITS_DEF = 8;
  localparam int ENTRY_W   = ABITS_DEF + DBITS_DEF;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_post_fifo.sv
// Posted-write queue of {addr,data} entries; push/pop take effect at the clock edge, head is combinational.
// RAM_POST_FWD_EN adds an address lookup returning the youngest matching queued entry's data.
module ram_post_fifo
  import ram_post_pkg::*;
#(
  parameter int EW    = ENTRY_W,
  parameter int DEPTH = 4
`ifdef RAM_POST_FWD_EN
  ,
  parameter int AW    = ABITS_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [EW-1:0]         push_dat,
  input  logic                  pop,
  output logic [EW-1:0]         head_dat,
  output logic                  full,
  output logic                  empty,
`ifdef RAM_POST_FWD_EN
  input  logic [AW-1:0]         lk_a,
  output logic                  lk_hit,
  output logic [EW-AW-1:0]      lk_d,
`endif
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // The caller never pushes while full or pops while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

`ifdef RAM_POST_FWD_EN
  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    lk_hit = 1'b0;
    lk_d   = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (mem[idx][EW-1 -: AW] == lk_a)) begin
        lk_hit = 1'b1;
        lk_d   = mem[idx][EW-AW-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/ram_post_buffer.sv
// Write-posting buffer: writes ack in 1 cycle (held off while full) and drain in order; reads go out after drain.
// With RAM_POST_FWD_EN, reads hitting a queued address are answered from the queue with 1-cycle latency.
module ram_post_buffer
  import ram_post_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [ABITS-1:0] m_a,
  input  logic [DBITS-1:0] m_d,
  output logic             m_ack,
  output logic [DBITS-1:0] m_q,
  output logic             s_req,
  output logic             s_we,
  output logic [ABITS-1:0] s_a,
  output logic [DBITS-1:0] s_d,
  input  logic             s_ack,
  input  logic [DBITS-1:0] s_q,
  output logic             idle
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ABITS + DBITS;

  state_t           state, state_nx;
  logic             s_req_nx, s_we_nx;
  logic [ABITS-1:0] s_a_nx;
  logic [DBITS-1:0] s_d_nx;
  logic             ack_wr, push, pop, full, empty;
  logic             wr_take, rd_wait, rd_done, fwd_take, ack_nx, idle_nx;
  logic [DBITS-1:0] fwd_d;
  logic [CW-1:0]    count, cnt_nx;
  logic [EW-1:0]    head_dat;
  logic [ABITS-1:0] head_a;
  logic [DBITS-1:0] head_d;

  // The !m_ack guard keeps a request still held during its ack cycle from being taken twice.
  assign wr_take = m_req && m_we && !m_ack && !full;
  assign rd_wait = m_req && !m_we && !m_ack;
  assign push    = ack_wr;
  assign head_a  = head_dat[EW-1 -: ABITS];
  assign head_d  = head_dat[DBITS-1:0];

`ifdef RAM_POST_FWD_EN
  logic lk_hit;
  logic [DBITS-1:0] lk_d;

  ram_post_fifo #(.EW(EW), .DEPTH(DEPTH), .AW(ABITS)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({m_a, m_d}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .lk_a     (m_a),
    .lk_hit   (lk_hit),
    .lk_d     (lk_d),
    .count    (count)
  );

  assign fwd_take = rd_wait && lk_hit;
  assign fwd_d    = lk_d;
`else
  ram_post_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({m_a, m_d}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign fwd_take = 1'b0;
  assign fwd_d    = '0;
`endif

  always_comb begin
    state_nx = state;
    s_req_nx = s_req;
    s_we_nx  = s_we;
    s_a_nx   = s_a;
    s_d_nx   = s_d;
    pop      = 1'b0;
    rd_done  = 1'b0;
    case (state)
      S_IDLE: begin
        // Queued writes always go first so a read observes every earlier write.
        if (!empty) begin
          state_nx = S_WR;
          s_req_nx = 1'b1;
          s_we_nx  = 1'b1;
          s_a_nx   = head_a;
          s_d_nx   = head_d;
        end else if (rd_wait) begin
          state_nx = S_RD;
          s_req_nx = 1'b1;
          s_we_nx  = 1'b0;
          s_a_nx   = m_a;
        end
      end
      S_WR: begin
        if (s_ack) begin
          pop      = 1'b1;
          s_req_nx = 1'b0;
          state_nx = S_IDLE;
        end
      end
      S_RD: begin
        if (s_ack) begin
          rd_done  = 1'b1;
          s_req_nx = 1'b0;
          state_nx = S_RDACK;
        end
      end
      S_RDACK: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign ack_nx  = wr_take || rd_done || fwd_take;
  assign cnt_nx  = count + CW'(push) - CW'(pop);
  assign idle_nx = (state_nx == S_IDLE) && (cnt_nx == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      s_req  <= 1'b0;
      s_we   <= 1'b0;
      s_a    <= '0;
      s_d    <= '0;
      m_ack  <= 1'b0;
      ack_wr <= 1'b0;
      m_q    <= '0;
      idle   <= 1'b1;
    end else begin
      state  <= state_nx;
      s_req  <= s_req_nx;
      s_we   <= s_we_nx;
      s_a    <= s_a_nx;
      s_d    <= s_d_nx;
      m_ack  <= ack_nx;
      ack_wr <= wr_take;
      idle   <= idle_nx;
      if (rd_done)       m_q <= s_q;
      else if (fwd_take) m_q <= fwd_d;
    end
  end

endmodule

// File: tb/tb_ram_post_buffer.sv
// Scoreboard bench for ram_post_buffer: a flat memory reference model predicts read data and drain order.
module tb_ram_post_buffer;

  localparam int DEPTH = 4;
`ifdef RAM_POST_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_req, m_we, m_ack, s_req, s_we, s_ack, idle;
  logic [23:0] m_a, s_a;
  logic [7:0]  m_d, m_q, s_d, s_q;

  always #5 clk = ~clk;

  ram_post_buffer #(.ABITS(24), .DBITS(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_we(m_we), .m_a(m_a), .m_d(m_d), .m_ack(m_ack), .m_q(m_q),
    .s_req(s_req), .s_we(s_we), .s_a(s_a), .s_d(s_d), .s_ack(s_ack), .s_q(s_q),
    .idle(idle)
  );

  int checks = 0, errors = 0, cyc = 0;
  typedef logic [7:0] mem_t [logic [23:0]];
  mem_t ref_mem, slave_mem;
  logic [31:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [23:0] rd_addr = '0;
  bit stall = 0, dly_rand = 0, in_txn = 0;
  int dly_fix = 0, wcnt = 0;
  int wr_acks = 0, sl_wr_acks = 0, sl_rd_cnt = 0, max_out = 0, sreq_seen = 0;
  int last_mack_cyc = 0, last_rd_sack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Untouched RAM locations read back a fixed address-derived pattern.
  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] slave_rd(input logic [23:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  // Arbitrator model: acks after a per-transaction delay unless stalled.
  initial begin
    s_ack = 1'b0;
    s_q   = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        s_ack  = 1'b0;
        in_txn = 1'b0;
      end else if (s_ack) begin
        s_ack = 1'b0;
      end else if (s_req && !stall) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt   = dly_rand ? int'($urandom_range(0, 3)) : dly_fix;
        end
        if (wcnt == 0) begin
          s_ack  = 1'b1;
          in_txn = 1'b0;
          if (s_we) slave_mem[s_a] = s_d;
          else      s_q = slave_rd(s_a);
        end else begin
          wcnt--;
        end
      end
    end
  end

  always @(negedge clk) begin : slave_mon
    logic [31:0] e;
    if (reset_n) begin
      if (s_req) sreq_seen++;
      if (s_req && s_ack) begin
        if (s_we) begin
          sl_wr_acks++;
          check("slave_wr_expected", 32'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("slave_wr_order", {s_a, s_d}, e);
          end
        end else begin
          sl_rd_cnt++;
          last_rd_sack_cyc = cyc;
          check("rd_after_drain", exp_wr.size(), 0);
          check("slave_rd_addr", s_a, rd_addr);
        end
      end
    end
  end

  always @(negedge clk) begin : master_mon
    if (reset_n && m_ack) begin
      if (m_we) begin
        wr_acks++;
        if (wr_acks - sl_wr_acks > max_out) max_out = wr_acks - sl_wr_acks;
      end else begin
        check("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) check("m_q", m_q, exp_rd.pop_front());
      end
    end
  end

  task automatic wait_ack(output int lat);
    int req_cyc, n;
    req_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ack && n < 300);
    if (!m_ack) begin
      checks++;
      errors++;
      $display("FAIL m_ack_timeout: no ack after %0d cycles, expected one", n);
    end
    last_mack_cyc = cyc;
    lat = cyc - req_cyc;
    @(posedge clk); #1;
    m_req = 1'b0;
    m_we  = 1'b0;
  endtask

  task automatic mwrite(input logic [23:0] a, input logic [7:0] d, output int lat);
    exp_wr.push_back({a, d});
    ref_mem[a] = d;
    m_req = 1'b1; m_we = 1'b1; m_a = a; m_d = d;
    wait_ack(lat);
  endtask

  task automatic mread(input logic [23:0] a, output int lat);
    exp_rd.push_back(ref_rd(a));
    rd_addr = a;
    m_req = 1'b1; m_we = 1'b0; m_a = a;
    wait_ack(lat);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(idle && !s_req && exp_wr.size() == 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, idle}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1);
  end

  initial begin
    int lat, lat5, n, ack5_cyc, sack1_cyc, rd0, s0, issued, base;
    logic [23:0] a;
    m_req = 1'b0; m_we = 1'b0; m_a = '0; m_d = '0;
    ack5_cyc = 0; sack1_cyc = 0; lat5 = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_m_ack", {31'd0, m_ack}, 0);
    check("rst_m_q",   m_q, 0);
    check("rst_s_req", {31'd0, s_req}, 0);
    check("rst_s_we",  {31'd0, s_we}, 0);
    check("rst_s_a",   s_a, 0);
    check("rst_s_d",   s_d, 0);
    check("rst_idle",  {31'd0, idle}, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single posted write.
    mwrite(24'h008000, 8'hA5, lat);
    check("t1_ack_lat", lat, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_req && n < 50);
    check("t1_sreq_lat", n, 2);
    check("t1_s_we", {31'd0, s_we}, 1);
    check("t1_s_a", s_a, 24'h008000);
    check("t1_s_d", s_d, 8'hA5);
    wait_idle("t1_idle");

    // Five writes against a stalled arbitrator: the fifth waits for a slot.
    stall = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          mwrite(24'h000100 + 24'(i), 8'(i), lat5);
          if (i <= 4) check("t2_ack_lat", lat5, 1);
        end
        ack5_cyc = last_mack_cyc;
      end
      begin
        repeat (15) @(posedge clk); #1;
        stall = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(s_req && s_ack) && n < 50);
        sack1_cyc = cyc;
      end
    join
    check("t2_ack5_after_pop", ack5_cyc - sack1_cyc, 2);
    wait_idle("t2_idle");

    // Read after write with slow arbitrator acks.
    dly_fix = 3;
    rd0 = sl_rd_cnt;
    mwrite(24'h000010, 8'h3C, lat);
    mread(24'h000010, lat);
    check("t3_rd_lat", lat, FWD ? 1 : 10);
    check("t3_slave_rd", sl_rd_cnt - rd0, FWD ? 0 : 1);
    wait_idle("t3_idle");
    mread(24'h000010, lat);
    check("t3b_rd_lat", lat, 5);
    check("t3b_sack_to_mack", last_mack_cyc - last_rd_sack_cyc, 1);

    // Two writes to one address, then a read while the arbitrator is stalled.
    dly_fix = 0;
    stall = 1'b1;
    mwrite(24'h000020, 8'h11, lat);
    mwrite(24'h000020, 8'h22, lat);
    rd0 = sl_rd_cnt;
    fork
      mread(24'h000020, lat);
      begin
        repeat (10) @(posedge clk); #1;
        stall = 1'b0;
      end
    join
    check("t4_fwd_lat1", {31'd0, lat == 1}, {31'd0, FWD});
    wait_idle("t4_idle");
    check("t4_slave_rd", sl_rd_cnt - rd0, FWD ? 0 : 1);

    // Pointer wrap and random traffic with random arbitrator delays.
    dly_rand = 1'b1;
    base = sl_wr_acks;
    issued = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      mwrite(24'h000300 + 24'($urandom_range(0, 7)), 8'($urandom), lat);
      issued++;
    end
    for (int i = 0; i < 40; i++) begin
      a = 24'h000300 + 24'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        mwrite(a, 8'($urandom), lat);
        issued++;
      end else begin
        mread(a, lat);
      end
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
    end
    wait_idle("t5_idle");
    check("t5_all_drained", sl_wr_acks - base, issued);
    check("t5_max_outstanding", {31'd0, max_out <= DEPTH}, 1);

    // Reset while draining: queued writes are discarded.
    dly_rand = 1'b0;
    dly_fix = 0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) mwrite(24'h000400 + 24'(i), 8'hE0 + 8'(i), lat);
    repeat (2) @(negedge clk);
    check("t6_pre_s_req", {31'd0, s_req}, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_s_req", {31'd0, s_req}, 0);
    check("t6_rst_m_ack", {31'd0, m_ack}, 0);
    exp_wr.delete();
    ref_mem = slave_mem;
    wr_acks = sl_wr_acks;
    stall = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    s0 = sreq_seen;
    repeat (10) @(negedge clk);
    check("t6_no_sreq", sreq_seen - s0, 0);
    check("t6_idle", {31'd0, idle}, 1);
    mread(24'h000401, lat);
    check("t6_rd_lat", lat, 2);

    repeat (5) @(posedge clk);
    check("end_exp_rd_empty", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
